// File: rtl/vending_pkg.sv
// Shared coin codes, denomination values, FSM encoding and error codes for the
// vending datapath (inbound money_counter and outbound change_dispenser).
package vending_pkg;

  localparam logic [1:0] COIN_500  = 2'b00;
  localparam logic [1:0] COIN_1000 = 2'b01;
  localparam logic [1:0] COIN_2000 = 2'b10;
  localparam logic [1:0] COIN_5000 = 2'b11;

  localparam logic [15:0] VAL_500  = 16'd5;
  localparam logic [15:0] VAL_1000 = 16'd10;
  localparam logic [15:0] VAL_2000 = 16'd20;
  localparam logic [15:0] VAL_5000 = 16'd50;

  localparam logic [1:0] ERR_OK        = 2'b00;
  localparam logic [1:0] ERR_UNALIGNED = 2'b01;
  localparam logic [1:0] ERR_INSUFF    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_EMIT, ST_DONE, ST_ERROR
  } state_t;

  // per-denomination 4-bit counters, indexed by coin code
  typedef logic [3:0][3:0] stock_t;

  function automatic logic [15:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_500:  coin_value = VAL_500;
      COIN_1000: coin_value = VAL_1000;
      COIN_2000: coin_value = VAL_2000;
      default:   coin_value = VAL_5000;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake: dispenser offers coin_out/coin_valid, hopper answers coin_ready.
interface change_dispenser_if;
  logic [1:0] coin_out;
  logic       coin_valid;
  logic       coin_ready;

  modport master (output coin_out, output coin_valid, input coin_ready);
  modport slave  (input coin_out, input coin_valid, output coin_ready);
endinterface

// File: rtl/change_denom_select.sv
// Greedy pick: largest denomination that fits in remaining and is still in stock.
module change_denom_select
  import vending_pkg::*;
(
  input  logic [15:0] remaining,
  input  stock_t      stock,
  output logic        found,
  output logic [1:0]  code,
  output logic [15:0] value
);

  always_comb begin
    found = 1'b0;
    code  = COIN_500;
    value = 16'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && stock[i] != 4'd0 && coin_value(2'(i)) <= remaining) begin
        found = 1'b1;
        code  = 2'(i);
        value = coin_value(2'(i));
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays change out one coin at a time over the hopper handshake.
// Optional hopper-stall timeout is built in when CHANGE_TIMEOUT_EN is defined.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [15:0]          change_amount,
  input  logic [3:0]           stock_500,
  input  logic [3:0]           stock_1000,
  input  logic [3:0]           stock_2000,
  input  logic [3:0]           stock_5000,
  change_dispenser_if.master   hop,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           error_code,
  output logic [15:0]          remaining,
  output logic [3:0]           paid_500,
  output logic [3:0]           paid_1000,
  output logic [3:0]           paid_2000,
  output logic [3:0]           paid_5000
);

  state_t      state, state_nx;
  logic [1:0]  err_nx;
  stock_t      stock_q, paid_q;
  logic        found;
  logic [1:0]  sel_code;
  logic [15:0] sel_value;
  logic        xfer, tmo_hit;

  // remaining and stock do not move while in EMIT, so the pick stays stable
  change_denom_select u_sel (
    .remaining (remaining),
    .stock     (stock_q),
    .found     (found),
    .code      (sel_code),
    .value     (sel_value)
  );

  assign hop.coin_valid = (state == ST_EMIT);
  assign hop.coin_out   = (state == ST_EMIT) ? sel_code : 2'b00;
  assign xfer           = hop.coin_valid && hop.coin_ready;
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_DONE) || (state == ST_ERROR);
  assign paid_500       = paid_q[COIN_500];
  assign paid_1000      = paid_q[COIN_1000];
  assign paid_2000      = paid_q[COIN_2000];
  assign paid_5000      = paid_q[COIN_5000];

`ifdef CHANGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              tmo_cnt <= '0;
    else if (state != ST_EMIT || hop.coin_ready) tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + 1'b1;
  end

  // fires on the TIMEOUT_CYCLES-th consecutive stalled cycle
  assign tmo_hit = hop.coin_valid && !hop.coin_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    err_nx   = error_code;
    case (state)
      ST_IDLE: if (start) begin
        state_nx = ST_SELECT;
        err_nx   = ERR_OK;
      end
      ST_SELECT: begin
        if (remaining == 16'd0) state_nx = ST_DONE;
        else if (remaining < VAL_500) begin
          state_nx = ST_ERROR;
          err_nx   = ERR_UNALIGNED;
        end else if (found) state_nx = ST_EMIT;
        else begin
          state_nx = ST_ERROR;
          err_nx   = ERR_INSUFF;
        end
      end
      ST_EMIT: begin
        if (tmo_hit) begin
          state_nx = ST_ERROR;
          err_nx   = ERR_TIMEOUT;
        end else if (xfer) state_nx = ST_SELECT;
      end
      ST_DONE, ST_ERROR: state_nx = ST_IDLE;
      default:           state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      error_code <= ERR_OK;
      remaining  <= '0;
      stock_q    <= '0;
      paid_q     <= '0;
    end else begin
      state      <= state_nx;
      error_code <= err_nx;
      if (state == ST_IDLE && start) begin
        remaining <= change_amount;
        stock_q   <= {stock_5000, stock_2000, stock_1000, stock_500};
        paid_q    <= '0;
      end else if (xfer) begin
        remaining          <= remaining - sel_value;
        stock_q[sel_code]  <= stock_q[sel_code] - 4'd1;
        paid_q[sel_code]   <= paid_q[sel_code] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed cases plus randomized
// requests checked against a greedy change-making model.
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] change_amount = '0;
  logic [3:0]  stock_500 = '0, stock_1000 = '0, stock_2000 = '0, stock_5000 = '0;
  logic        busy, done;
  logic [1:0]  error_code;
  logic [15:0] remaining;
  logic [3:0]  paid_500, paid_1000, paid_2000, paid_5000;

  change_dispenser_if hop ();

  change_dispenser #(.TIMEOUT_CYCLES(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .change_amount (change_amount),
    .stock_500     (stock_500),
    .stock_1000    (stock_1000),
    .stock_2000    (stock_2000),
    .stock_5000    (stock_5000),
    .hop           (hop),
    .busy          (busy),
    .done          (done),
    .error_code    (error_code),
    .remaining     (remaining),
    .paid_500      (paid_500),
    .paid_1000     (paid_1000),
    .paid_2000     (paid_2000),
    .paid_5000     (paid_5000)
  );

  always #5 clock = ~clock;

  int vec = 0;
  int errs = 0;

  // model state: coin values by code 0..3 and expected outcome
  int den [4] = '{5, 10, 20, 50};
  int exp_q [$];
  int exp_paid [4];
  int exp_rem;
  int exp_code;

  task automatic model(input int amt, input int s0, input int s1, input int s2, input int s3);
    int st [4];
    int rem, pick;
    st = '{s0, s1, s2, s3};
    exp_q.delete();
    exp_paid = '{0, 0, 0, 0};
    rem = amt;
    while (1) begin
      if (rem == 0) begin exp_code = 0; break; end
      if (rem < 5) begin exp_code = 1; break; end
      pick = -1;
      for (int c = 3; c >= 0; c--)
        if (pick < 0 && st[c] > 0 && den[c] <= rem) pick = c;
      if (pick < 0) begin exp_code = 2; break; end
      exp_q.push_back(pick);
      rem -= den[pick];
      st[pick]--;
      exp_paid[pick]++;
    end
    exp_rem = rem;
  endtask

  task automatic run_req(input int amt, input int s0, input int s1, input int s2, input int s3,
                         input int stall_pct, input bit poke, input string tag);
    int idx, lows;
    logic [1:0] held;
    logic held_v, seen;
    model(amt, s0, s1, s2, s3);
    change_amount = 16'(amt);
    stock_500 = 4'(s0); stock_1000 = 4'(s1); stock_2000 = 4'(s2); stock_5000 = 4'(s3);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    // inputs change after the accepted start; the latched values must be used
    change_amount = 16'hFFFF;
    stock_500 = 4'($urandom); stock_1000 = 4'($urandom);
    stock_2000 = 4'($urandom); stock_5000 = 4'($urandom);
    idx = 0; lows = 0; held = 2'b00; held_v = 1'b0; seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (poke && cyc == 3) start = 1'b1;
      else if (poke && cyc == 4) start = 1'b0;
      if (int'($urandom_range(99)) < stall_pct && lows < 5) begin
        hop.coin_ready = 1'b0; lows++;
      end else begin
        hop.coin_ready = 1'b1; lows = 0;
      end
      if (held_v) begin
        vec++;
        if (hop.coin_valid !== 1'b1 || hop.coin_out !== held) begin
          errs++;
          $display("FAIL %s stall_hold: got v=%b c=%0d want v=1 c=%0d", tag, hop.coin_valid, hop.coin_out, held);
        end
      end
      if (hop.coin_valid && hop.coin_ready) begin
        vec++;
        if (idx >= exp_q.size() || hop.coin_out !== 2'(exp_q[idx])) begin
          errs++;
          $display("FAIL %s coin[%0d]: got %0d want %0d", tag, idx, hop.coin_out,
                   (idx < exp_q.size()) ? exp_q[idx] : -1);
        end
        idx++;
      end
      held_v = hop.coin_valid && !hop.coin_ready;
      held   = hop.coin_out;
      if (done) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
    hop.coin_ready = 1'b0;
    vec++;
    if (seen !== 1'b1) begin errs++; $display("FAIL %s done_seen: got 0 want 1 within budget", tag); end
    vec++;
    if (idx != exp_q.size()) begin errs++; $display("FAIL %s coin_count: got %0d want %0d", tag, idx, exp_q.size()); end
    vec++;
    if (error_code !== 2'(exp_code)) begin errs++; $display("FAIL %s error_code: got %0d want %0d", tag, error_code, exp_code); end
    vec++;
    if (remaining !== 16'(exp_rem)) begin errs++; $display("FAIL %s remaining: got %0d want %0d", tag, remaining, exp_rem); end
    vec++;
    if ({paid_5000, paid_2000, paid_1000, paid_500} !==
        {4'(exp_paid[3]), 4'(exp_paid[2]), 4'(exp_paid[1]), 4'(exp_paid[0])}) begin
      errs++;
      $display("FAIL %s paid: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", tag,
               paid_500, paid_1000, paid_2000, paid_5000, exp_paid[0], exp_paid[1], exp_paid[2], exp_paid[3]);
    end
    @(posedge clock); #1;
    start = 1'b0;
    vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0/0", tag, done, busy);
    end
  endtask

  task automatic test_reset;
    #2;
    vec++;
    if ({hop.coin_valid, hop.coin_out, busy, done, error_code, remaining,
         paid_500, paid_1000, paid_2000, paid_5000} !== '0) begin
      errs++; $display("FAIL reset_values: got v=%b busy=%b done=%b err=%0d rem=%0d", hop.coin_valid, busy, done, error_code, remaining);
    end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_spec_examples;
    run_req(85, 3, 3, 3, 3, 0, 1'b0, "amt85");
    run_req(7,  3, 3, 3, 3, 0, 1'b0, "amt7");
    run_req(60, 0, 0, 3, 1, 0, 1'b0, "amt60");
  endtask

  task automatic test_zero;
    logic saw_valid;
    change_amount = 16'd0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    saw_valid = hop.coin_valid;
    vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL zero_cyc1: got done=%b busy=%b want 0/1", done, busy); end
    @(posedge clock); #1;
    saw_valid = saw_valid | hop.coin_valid;
    vec++;
    if (done !== 1'b1 || error_code !== 2'd0) begin errs++; $display("FAIL zero_cyc2: got done=%b err=%0d want 1/0", done, error_code); end
    @(posedge clock); #1;
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || saw_valid !== 1'b0) begin
      errs++; $display("FAIL zero_end: got done=%b busy=%b valid_seen=%b want 0/0/0", done, busy, saw_valid);
    end
  endtask

  task automatic test_stall_reset;
    change_amount = 16'd85;
    stock_500 = 4'd3; stock_1000 = 4'd3; stock_2000 = 4'd3; stock_5000 = 4'd3;
    hop.coin_ready = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (hop.coin_valid !== 1'b1 || hop.coin_out !== 2'd3 || remaining !== 16'd85) begin
        errs++; $display("FAIL stall_wait[%0d]: got v=%b c=%0d rem=%0d want 1/3/85", i, hop.coin_valid, hop.coin_out, remaining);
      end
      if (i < 4) begin @(posedge clock); #1; end
    end
    hop.coin_ready = 1'b1;
    @(posedge clock); #1;
    hop.coin_ready = 1'b0;
    vec++;
    if (hop.coin_valid !== 1'b0 || remaining !== 16'd35 || paid_5000 !== 4'd1) begin
      errs++; $display("FAIL stall_xfer: got v=%b rem=%0d p5000=%0d want 0/35/1", hop.coin_valid, remaining, paid_5000);
    end
    @(posedge clock); #1;
    vec++;
    if (hop.coin_valid !== 1'b1 || hop.coin_out !== 2'd2) begin
      errs++; $display("FAIL second_coin: got v=%b c=%0d want 1/2", hop.coin_valid, hop.coin_out);
    end
    #2 reset_n = 1'b0;
    #1;
    vec++;
    if ({hop.coin_valid, hop.coin_out, busy, done, error_code, remaining,
         paid_500, paid_1000, paid_2000, paid_5000} !== '0) begin
      errs++; $display("FAIL async_reset: got v=%b busy=%b rem=%0d p5000=%0d want all 0", hop.coin_valid, busy, remaining, paid_5000);
    end
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    vec++;
    if (busy !== 1'b0 || hop.coin_valid !== 1'b0) begin
      errs++; $display("FAIL after_reset: got busy=%b v=%b want 0/0", busy, hop.coin_valid);
    end
  endtask

  task automatic test_random;
    int amt;
    for (int n = 0; n < 40; n++) begin
      amt = int'($urandom_range(60)) * 5;
      if ($urandom_range(3) == 0) amt += int'($urandom_range(4, 1));
      run_req(amt, int'($urandom_range(15)), int'($urandom_range(6)), int'($urandom_range(4)),
              int'($urandom_range(3)), 30, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 6; n++)
      run_req(int'($urandom_range(40)) * 5, 4, 2, 2, 1, 20, 1'b1, "b2b");
  endtask

`ifdef CHANGE_TIMEOUT_EN
  task automatic test_timeout;
    int vcnt;
    logic seen;
    change_amount = 16'd50;
    stock_500 = 4'd3; stock_1000 = 4'd3; stock_2000 = 4'd3; stock_5000 = 4'd3;
    hop.coin_ready = 1'b0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    vcnt = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (hop.coin_valid) vcnt++;
      if (done) begin seen = 1'b1; break; end
      @(posedge clock); #1;
    end
    vec++;
    if (seen !== 1'b1 || vcnt != 8 || error_code !== 2'd3) begin
      errs++; $display("FAIL timeout: got done=%b valid_cycles=%0d err=%0d want 1/8/3", seen, vcnt, error_code);
    end
    vec++;
    if (remaining !== 16'd50 || paid_5000 !== 4'd0) begin
      errs++; $display("FAIL timeout_rem: got rem=%0d p5000=%0d want 50/0", remaining, paid_5000);
    end
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    hop.coin_ready = 1'b0;
    test_reset;
    test_spec_examples;
    test_zero;
    test_stall_reset;
    test_random;
    test_back_to_back;
`ifdef CHANGE_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
